// File: rtl/vga_timing_rx.sv
// vga_timing_rx: VGA sync/blank sink recovering pixel coordinates, line/frame geometry and lock status
// Define VGA_RX_SYNC_EN to pass VGA_HS/VGA_VS/VGA_BLANK_N through a 2-flop synchronizer.
module vga_timing_rx #(
    parameter int H_W         = 11,
    parameter int V_W         = 10,
    parameter int LOCK_FRAMES = 2
) (
    input  logic           CLOCK_50,
    input  logic           RESET_N,
    input  logic           PIX_CE,
    input  logic           VGA_HS,
    input  logic           VGA_VS,
    input  logic           VGA_BLANK_N,
    output logic [H_W-1:0] PIX_X,
    output logic [V_W-1:0] PIX_Y,
    output logic           PIX_VALID,
    output logic [H_W-1:0] LINE_LEN,
    output logic [V_W-1:0] FRAME_LINES,
    output logic [H_W-1:0] ACT_W,
    output logic [V_W-1:0] ACT_H,
    output logic           LOCKED,
    output logic           ERR,
    output logic [7:0]     ERR_CNT
);
    typedef enum logic [1:0] {SEARCH, TRACK, LOCK} state_t;
    state_t state, state_n;
    logic hs, vs, bn;
`ifdef VGA_RX_SYNC_EN
    logic [2:0] sync1, sync2;
    always_ff @(posedge CLOCK_50 or negedge RESET_N)
        if (!RESET_N) begin
            sync1 <= 3'b110;
            sync2 <= 3'b110;
        end else begin
            sync1 <= {VGA_HS, VGA_VS, VGA_BLANK_N};
            sync2 <= sync1;
        end
    assign {hs, vs, bn} = sync2;
`else
    assign {hs, vs, bn} = {VGA_HS, VGA_VS, VGA_BLANK_N};
`endif
    logic           hs_prev, vs_prev, line_act, hs_fall, vs_fall, la_line, h_sat, v_sat, err_n;
    logic [H_W-1:0] h_cnt, x_cnt, x_base, new_len, len_now, ref_len, ref_len_n;
    logic [V_W-1:0] v_cnt, y_cnt, y_line, y_base, ref_lines, ref_lines_n;
    logic [3:0]     match, match_n;
    logic [7:0]     err_cnt_n;
    assign hs_fall = PIX_CE & hs_prev & ~hs;
    assign vs_fall = PIX_CE & vs_prev & ~vs;
    assign h_sat   = &h_cnt;
    assign v_sat   = &v_cnt;
    assign new_len = h_cnt + H_W'(1);
    assign len_now = hs_fall ? new_len : LINE_LEN;
    // Line-end bookkeeping is folded in before frame-end so a coincident HS+VS fall closes the line first
    assign la_line = line_act & ~hs_fall;
    assign y_line  = (hs_fall & line_act) ? y_cnt + V_W'(1) : y_cnt;
    assign x_base  = hs_fall ? '0 : x_cnt;
    assign y_base  = vs_fall ? '0 : y_line;
    assign LOCKED  = state == LOCK;
    always_ff @(posedge CLOCK_50 or negedge RESET_N)
        if (!RESET_N) begin
            hs_prev     <= 1'b1;
            vs_prev     <= 1'b1;
            line_act    <= 1'b0;
            h_cnt       <= '0;
            x_cnt       <= '0;
            v_cnt       <= '0;
            y_cnt       <= '0;
            PIX_X       <= '0;
            PIX_Y       <= '0;
            PIX_VALID   <= 1'b0;
            LINE_LEN    <= '0;
            FRAME_LINES <= '0;
            ACT_W       <= '0;
            ACT_H       <= '0;
        end else if (PIX_CE) begin
            hs_prev   <= hs;
            vs_prev   <= vs;
            h_cnt     <= hs_fall ? '0 : h_sat ? h_cnt : h_cnt + H_W'(1);
            v_cnt     <= vs_fall ? V_W'(hs_fall) : (hs_fall && !v_sat) ? v_cnt + V_W'(1) : v_cnt;
            x_cnt     <= bn ? x_base + H_W'(1) : x_base;
            y_cnt     <= y_base;
            line_act  <= bn | (la_line & ~vs_fall);
            PIX_VALID <= bn;
            if (bn) begin
                PIX_X <= x_base;
                PIX_Y <= y_base;
            end
            if (hs_fall) begin
                LINE_LEN <= new_len;
                ACT_W    <= x_cnt;
            end
            if (vs_fall) begin
                FRAME_LINES <= v_cnt;
                ACT_H       <= y_line + V_W'(la_line);
            end
        end
    always_ff @(posedge CLOCK_50 or negedge RESET_N)
        if (!RESET_N) begin
            state     <= SEARCH;
            ref_len   <= '0;
            ref_lines <= '0;
            match     <= '0;
            ERR       <= 1'b0;
            ERR_CNT   <= '0;
        end else begin
            state     <= state_n;
            ref_len   <= ref_len_n;
            ref_lines <= ref_lines_n;
            match     <= match_n;
            ERR       <= err_n;
            ERR_CNT   <= err_cnt_n;
        end
    always_comb begin
        state_n     = state;
        ref_len_n   = ref_len;
        ref_lines_n = ref_lines;
        match_n     = match;
        err_n       = 1'b0;
        err_cnt_n   = ERR_CNT;
        if (PIX_CE) begin
            if (h_sat || v_sat) state_n = SEARCH;
            else if (state == SEARCH) begin
                if (vs_fall) begin
                    state_n     = TRACK;
                    match_n     = '0;
                    ref_len_n   = len_now;
                    ref_lines_n = v_cnt;
                end
            end else if (state == TRACK) begin
                if (vs_fall && len_now == ref_len && v_cnt == ref_lines) begin
                    match_n = match + 4'd1;
                    if (match_n >= 4'(LOCK_FRAMES - 1)) state_n = LOCK;
                end else if (vs_fall) begin
                    match_n     = '0;
                    ref_len_n   = len_now;
                    ref_lines_n = v_cnt;
                end
            end else if ((hs_fall && new_len != ref_len) || (vs_fall && v_cnt != ref_lines)) begin
                err_n       = 1'b1;
                err_cnt_n   = ERR_CNT + 8'(~&ERR_CNT);
                state_n     = TRACK;
                match_n     = '0;
                ref_len_n   = len_now;
                ref_lines_n = vs_fall ? v_cnt : ref_lines;
            end
        end
    end
endmodule
